// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared constants for the tenyr interrupt scheduler --
// source count, vector width, register offsets and FSM state encoding.
package irq_sched_pkg;

   localparam int IRQ_COUNT = 32;
   localparam int IDX_BITS  = 5;

   localparam logic [2:0] ADDR_PEND   = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd1;
   localparam logic [2:0] ADDR_MODE   = 3'd2;
   localparam logic [2:0] ADDR_INSV   = 3'd3;
   localparam logic [2:0] ADDR_SWSET  = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1
   } state_t;

endpackage

// File: rtl/prio_enc32.sv
// prio_enc32: 32-bit find-first-set; index 0 is highest priority.
// valid_o is low when no request bit is set (idx_o is then 0).
module prio_enc32
   import irq_sched_pkg::*;
(
   input  logic [IRQ_COUNT-1:0] req_i,
   output logic [IDX_BITS-1:0]  idx_o,
   output logic                 valid_o
);

   // scan from the top down so the lowest set index is the one left standing
   always_comb begin
      idx_o   = '0;
      valid_o = |req_i;
      for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = i[IDX_BITS-1:0];
      end
   end

endmodule

// File: rtl/irq_sched.sv
// irq_sched: 32-source interrupt priority scheduler with trap/ack handshake
// and a small register port. Define IRQ_SCHED_NEST_EN to allow strictly
// higher-priority sources to preempt while others are in service; without it
// no trap is raised while any source is in service.
module irq_sched
   import irq_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [IRQ_COUNT-1:0] irq,
   input  logic                 strobe,
   input  logic                 rw,
   input  logic [2:0]           addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   output logic                 trap,
   output logic [IDX_BITS-1:0]  vec,
   input  logic                 ack
);

`ifdef IRQ_SCHED_NEST_EN
   localparam bit NEST_EN = 1'b1;
`else
   localparam bit NEST_EN = 1'b0;
`endif

   state_t                state_q, state_d;
   logic [IDX_BITS-1:0]   vec_q, vec_d;
   logic [IRQ_COUNT-1:0]  irq_prev_q;
   logic [IRQ_COUNT-1:0]  pend_q, pend_d;   // edge-latched and software-set bits
   logic [IRQ_COUNT-1:0]  mask_q, mode_q;
   logic [IRQ_COUNT-1:0]  insv_q, insv_d;
   logic [31:0]           rdata_q, rd_mux;

   logic                  wr_en;
   logic [IRQ_COUNT-1:0]  pend, rise, pend_w1c, insv_w1c, swset;
   logic [IRQ_COUNT-1:0]  below_mask, prio_ok, eligible, ack_onehot;
   logic [IDX_BITS-1:0]   insv_idx, elig_idx;
   logic                  insv_any, elig_any, ack_take;

   // lowest in-service source bounds which sources may still preempt
   prio_enc32 u_insv_enc (.req_i(insv_q),   .idx_o(insv_idx), .valid_o(insv_any));
   prio_enc32 u_elig_enc (.req_i(eligible), .idx_o(elig_idx), .valid_o(elig_any));

   // pending view, write decode and eligibility
   always_comb begin
      wr_en      = strobe & rw;
      rise       = irq & ~irq_prev_q;
      // level sources follow the line, with the software bit ORed in
      pend       = (mode_q & pend_q) | (~mode_q & (irq | pend_q));
      pend_w1c   = (wr_en && addr == ADDR_PEND)  ? wdata : '0;
      insv_w1c   = (wr_en && addr == ADDR_INSV)  ? wdata : '0;
      swset      = (wr_en && addr == ADDR_SWSET) ? wdata : '0;
      below_mask = (32'h1 << insv_idx) - 32'h1;
      prio_ok    = insv_any ? (NEST_EN ? below_mask : '0) : '1;
      eligible   = pend & mask_q & ~insv_q & prio_ok;
   end

   // FSM next state: latch a vector in IDLE, hold it through REQ
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      ack_take = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (elig_any) begin
               vec_d   = elig_idx;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack) begin
               ack_take = 1'b1;
               state_d  = ST_IDLE;
            end else if (!(pend[vec_q] && mask_q[vec_q])) begin
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // register next values: sets beat clears on PEND, W1C beats ack on INSV
   always_comb begin
      ack_onehot = ack_take ? (32'h1 << vec_q) : '0;
      pend_d     = (pend_q & ~(pend_w1c | ack_onehot)) | swset | (mode_q & rise);
      insv_d     = (insv_q | ack_onehot) & ~insv_w1c;
      rd_mux     = '0;
      case (addr)
         ADDR_PEND:   rd_mux = pend;
         ADDR_MASK:   rd_mux = mask_q;
         ADDR_MODE:   rd_mux = mode_q;
         ADDR_INSV:   rd_mux = insv_q;
         ADDR_STATUS: rd_mux = {22'b0, state_q, 3'b0, vec_q};
         default:     rd_mux = '0;
      endcase
   end

   // state and register file update
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         vec_q      <= '0;
         irq_prev_q <= '0;
         pend_q     <= '0;
         mask_q     <= '0;
         mode_q     <= '0;
         insv_q     <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         irq_prev_q <= irq;
         pend_q     <= pend_d;
         insv_q     <= insv_d;
         if (wr_en && addr == ADDR_MASK) mask_q <= wdata;
         if (wr_en && addr == ADDR_MODE) mode_q <= wdata;
         if (strobe && !rw)              rdata_q <= rd_mux;
      end
   end

   assign trap  = (state_q == ST_REQ);
   assign vec   = vec_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: directed test of irq_sched. Honours IRQ_SCHED_NEST_EN when
// the same macro is defined for the build.
module tb_irq_sched;
   import irq_sched_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [IRQ_COUNT-1:0] irq;
   logic                 strobe, rw, ack;
   logic [2:0]           addr;
   logic [31:0]          wdata, rdata, r;
   logic                 trap;
   logic [IDX_BITS-1:0]  vec;
   int                   n_checks = 0;
   int                   n_errors = 0;

   irq_sched dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .strobe(strobe), .rw(rw),
      .addr(addr), .wdata(wdata), .rdata(rdata), .trap(trap), .vec(vec),
      .ack(ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      strobe = 1'b1; rw = 1'b1; addr = a; wdata = d;
      tick();
      strobe = 1'b0; rw = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      strobe = 1'b1; rw = 1'b0; addr = a;
      tick();
      strobe = 1'b0;
      d = rdata;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; irq = '0; strobe = 1'b0; rw = 1'b0; ack = 1'b0;
      addr = '0; wdata = '0;
      tick(); tick();
      reset_n = 1'b1;
      check("rst_trap", {31'b0, trap}, 32'h0);
      check("rst_vec", {27'b0, vec}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      rd(ADDR_PEND, r); check("rst_pend", r, 32'h0);
      rd(ADDR_MASK, r); check("rst_mask", r, 32'h0);
      rd(ADDR_INSV, r); check("rst_insv", r, 32'h0);

      // all enabled; every source edge-triggered except 2 (level)
      wr(ADDR_MASK, 32'hFFFF_FFFF);
      wr(ADDR_MODE, 32'hFFFF_FFFB);
      rd(ADDR_MODE, r); check("mode_rb", r, 32'hFFFF_FFFB);

      // edge irq[3]: trap two edges after the rising sample
      irq = 32'h8; tick(); irq = '0;
      check("e3_trap_early", {31'b0, trap}, 32'h0);
      tick();
      check("e3_trap", {31'b0, trap}, 32'h1);
      check("e3_vec", {27'b0, vec}, 32'd3);
      do_ack();
      check("e3_trap_after_ack", {31'b0, trap}, 32'h0);
      rd(ADDR_INSV, r); check("e3_insv", r, 32'h8);
      rd(ADDR_PEND, r); check("e3_pend", r, 32'h0);

`ifdef IRQ_SCHED_NEST_EN
      // only sources above the in-service one may preempt
      irq = 32'h82; tick(); irq = '0; tick();
      check("nest_trap1", {31'b0, trap}, 32'h1);
      check("nest_vec1", {27'b0, vec}, 32'd1);
      do_ack();
      rd(ADDR_INSV, r); check("nest_insv", r, 32'hA);
      wr(ADDR_INSV, 32'h2);
      check("nest_hold7", {31'b0, trap}, 32'h0);
      wr(ADDR_INSV, 32'h8);
      check("nest_eoi_trap", {31'b0, trap}, 32'h0);
      tick();
      check("nest_trap7", {31'b0, trap}, 32'h1);
      check("nest_vec7", {27'b0, vec}, 32'd7);
      do_ack();
      wr(ADDR_INSV, 32'h80);
`else
      // nothing traps while a source is in service
      irq = 32'h1; tick(); irq = '0; tick(); tick();
      check("nonest_blocked", {31'b0, trap}, 32'h0);
      rd(ADDR_PEND, r); check("nonest_pend", r, 32'h1);
      check("nonest_blocked2", {31'b0, trap}, 32'h0);
      wr(ADDR_INSV, 32'h8);
      check("nonest_eoi_trap", {31'b0, trap}, 32'h0);
      tick();
      check("nonest_trap", {31'b0, trap}, 32'h1);
      check("nonest_vec", {27'b0, vec}, 32'd0);
      rd(ADDR_STATUS, r); check("nonest_status", r, 32'h0000_0100);
      do_ack();
      wr(ADDR_INSV, 32'h1);
`endif
      rd(ADDR_INSV, r); check("insv_clear", r, 32'h0);

      // withdrawal by masking the latched source
      irq = 32'h20; tick(); irq = '0; tick();
      check("wd_trap", {31'b0, trap}, 32'h1);
      check("wd_vec", {27'b0, vec}, 32'd5);
      wr(ADDR_MASK, 32'hFFFF_FFDF);
      check("wd_trap_hold", {31'b0, trap}, 32'h1);
      tick();
      check("wd_trap_drop", {31'b0, trap}, 32'h0);
      rd(ADDR_STATUS, r); check("wd_state", {30'b0, r[9:8]}, 32'h0);
      rd(ADDR_PEND, r); check("wd_pend", r, 32'h20);
      wr(ADDR_PEND, 32'h20);
      wr(ADDR_MASK, 32'hFFFF_FFFF);

      // software set
      wr(ADDR_SWSET, 32'h200);
      tick();
      check("sw_trap", {31'b0, trap}, 32'h1);
      check("sw_vec", {27'b0, vec}, 32'd9);
      do_ack();
      rd(ADDR_PEND, r); check("sw_pend", r, 32'h0);
      wr(ADDR_INSV, 32'h200);

      // level irq[2] held: re-traps after EOI, clears when line drops
      irq = 32'h4; tick();
      check("lv_trap", {31'b0, trap}, 32'h1);
      check("lv_vec", {27'b0, vec}, 32'd2);
      do_ack();
      check("lv_trap_ack", {31'b0, trap}, 32'h0);
      rd(ADDR_PEND, r); check("lv_pend_held", r, 32'h4);
      wr(ADDR_INSV, 32'h4);
      tick();
      check("lv_retrap", {31'b0, trap}, 32'h1);
      check("lv_revec", {27'b0, vec}, 32'd2);
      do_ack();
      irq = '0;
      wr(ADDR_INSV, 32'h4);
      rd(ADDR_PEND, r); check("lv_pend_drop", r, 32'h0);

      // unmapped addresses
      wr(3'd7, 32'hFFFF_FFFF);
      rd(3'd7, r); check("unmapped", r, 32'h0);

      // rising edge and W1C of the same PEND bit: set wins
      strobe = 1'b1; rw = 1'b1; addr = ADDR_PEND; wdata = 32'h10; irq = 32'h10;
      tick();
      strobe = 1'b0; rw = 1'b0; irq = '0;
      rd(ADDR_PEND, r); check("setwins_pend", r, 32'h10);
      check("setwins_trap", {31'b0, trap}, 32'h1);
      check("setwins_vec", {27'b0, vec}, 32'd4);

      // reset mid-REQ with an ack in flight
      reset_n = 1'b0; ack = 1'b1;
      tick();
      reset_n = 1'b1; ack = 1'b0;
      check("rst2_trap", {31'b0, trap}, 32'h0);
      check("rst2_rdata", rdata, 32'h0);
      rd(ADDR_PEND, r);   check("rst2_pend", r, 32'h0);
      rd(ADDR_MASK, r);   check("rst2_mask", r, 32'h0);
      rd(ADDR_MODE, r);   check("rst2_mode", r, 32'h0);
      rd(ADDR_INSV, r);   check("rst2_insv", r, 32'h0);
      rd(ADDR_STATUS, r); check("rst2_status", r, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // overall time bound
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/irq_sched.md
# irq_sched

Interrupt priority scheduler feeding the tenyr external interrupt path. Collects 32 raw interrupt sources and applies per-source enable and edge/level mode. Selects the highest-priority eligible source and presents it to the core as a single trap request with a vector index, using a trap/ack handshake. Tracks in-service sources so only strictly higher priority can preempt; software programs and services it through a small register port on the data bus.

## Interface
- `IRQ_COUNT`, 32: number of sources; index 0 is highest priority.
- `IDX_BITS`, 5: width of vector index (log2 `IRQ_COUNT`).
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `irq` in `IRQ_COUNT`: raw source lines, already synchronous to `clk`.
- `strobe` in 1: register access valid this cycle.
- `rw` in 1: 1 = write, 0 = read.
- `addr` in 3: register select.
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `trap` out 1: interrupt request to core.
- `vec` out `IDX_BITS`: index of requested source; stable while `trap`=1.
- `ack` in 1: one-cycle pulse, core has taken the trap.

## Operation
- Registers (`addr`):
  - 0 PEND: read; write-1-to-clear.
  - 1 MASK: RW, 1 = enabled.
  - 2 MODE: RW, 1 = edge, 0 = level.
  - 3 INSV: read; write-1-to-clear (EOI).
  - 4 SWSET: write-1-to-set PEND.
  - 5 STATUS: {state[1:0] at [9:8], vec at [4:0]}.
  - Unmapped: reads return 0, writes are ignored.
- PEND, edge mode: bit set on `irq` rising edge (previous-sample register) or SWSET. Cleared by W1C or by `ack` for the latched vector. A set and a clear in the same cycle: set wins.
- PEND, level mode: bit = `irq` | SWSET-latched bit. Only the software bit is cleared by W1C or `ack`.
- Eligible = PEND & MASK & ~INSV & prio_ok. prio_ok = index below lowest set INSV bit (all ones when INSV = 0).
- FSM:
  - IDLE: any eligible → latch lowest eligible index into `vec`, go REQ.
  - REQ: `trap`=1.
    - `ack` → set INSV[vec], clear PEND[vec] per mode rules, go IDLE.
    - Latched source no longer PEND&MASK (W1C or mask cleared) and no `ack` → withdraw, go IDLE.
    - A higher-priority arrival during REQ does not replace `vec`; it is taken after return to IDLE.
- `ack` outside REQ is ignored.
- An `ack` and an INSV W1C in the same cycle both apply. A W1C to the bit being acked wins over the set.
- Level source still asserted after EOI re-pends immediately and re-traps.
- Reset values: PEND, MASK, MODE, INSV, SWSET latch, previous-`irq` register = 0; state IDLE; `trap`=0, `vec`=0, `rdata`=0.

## Timing
- `irq` rising at edge N → PEND visible after N → `trap`=1 and `vec` valid after edge N+1.
- `ack` sampled at edge M → `trap`=0 after M. Next `trap` no earlier than after edge M+1 (one IDLE cycle).
- Withdrawal: `trap` drops after the edge at which the condition is sampled.
- Read: `strobe&~rw` at edge K → `rdata` valid after K, held until the next read.
- Write effects are visible in registers after the write edge. Eligibility sees them next cycle.
- Reset mid-REQ: `trap` drops after the reset edge. All state is cleared; in-flight `ack` is lost.

## Configuration
- `IRQ_SCHED_NEST_EN` defined: preemption as above via prio_ok.
- Undefined: prio_ok = (INSV == 0). No trap is raised while any source is in service. The rest is unchanged.

## Structure
- Package `irq_sched_pkg`: register offsets, state encoding (IDLE=0, REQ=1), `IRQ_COUNT`, `IDX_BITS`.
- Sub-module `prio_enc32`: find-first-set with valid flag. Instantiated twice: eligible select and lowest INSV for prio_ok.

## Test plan
- MASK=1, MODE=1, pulse `irq[3]` one cycle → `trap`=1, `vec`=3 two edges later. `ack` → INSV=0x8, PEND=0, `trap`=0.
- NEST_EN, INSV bit 3 set, pulse `irq[7]` and `irq[1]` → only vec=1 traps. After EOI of 1 and 3, vec=7 traps.
- NEST_EN undefined, INSV bit 3 set, pulse `irq[0]` → no trap until INSV W1C 0x8, then `vec`=0.
- In REQ with vec=5, write MASK=0 → `trap` drops next cycle, state IDLE, PEND bit 5 still 1.
- Level `irq[2]` held high, ack then EOI → re-trap `vec`=2. Drop `irq[2]` → PEND bit 2 = 0.
- Edge on `irq[4]` same cycle as PEND W1C 0x10 → PEND bit 4 = 1. Assert `reset_n`=0 mid-REQ → `trap`=0, all registers 0.
